// File: rtl/tluh_sram_responder.sv
// rtl/tluh_sram_responder.sv - TL-UH device responder for a single-port 1-cycle SRAM
// Serves Get/Put, executes arithmetic/logical atomics as read-modify-write, acks Intent.
package tluh_pkg;
   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tluh_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tluh_d2h_t;

   localparam logic [2:0] OP_PUT_FULL    = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] OP_ARITH       = 3'd2;
   localparam logic [2:0] OP_LOGIC       = 3'd3;
   localparam logic [2:0] OP_GET         = 3'd4;
   localparam logic [2:0] OP_INTENT      = 3'd5;

   localparam logic [2:0] RSP_ACK      = 3'd0;
   localparam logic [2:0] RSP_ACK_DATA = 3'd1;
   localparam logic [2:0] RSP_HINT_ACK = 3'd2;

   localparam logic [2:0] ARITH_MIN  = 3'd1;
   localparam logic [2:0] ARITH_MAX  = 3'd2;
   localparam logic [2:0] ARITH_MINU = 3'd3;
   localparam logic [2:0] ARITH_MAXU = 3'd4;
   localparam logic [2:0] ARITH_ADD  = 3'd5;

   localparam logic [2:0] LOGIC_XOR  = 3'd1;
   localparam logic [2:0] LOGIC_OR   = 3'd2;
   localparam logic [2:0] LOGIC_AND  = 3'd3;
   localparam logic [2:0] LOGIC_SWAP = 3'd4;
endpackage

module tluh_sram_responder
   import tluh_pkg::*;
#(
   parameter int SramAw = 12
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  tluh_h2d_t         tl_i,
   output tluh_d2h_t         tl_o,
   output logic              req_o,
   output logic              we_o,
   output logic [SramAw-1:0] addr_o,
   output logic [31:0]       wdata_o,
   output logic [31:0]       wmask_o,
   input  logic [31:0]       rdata_i
);
   typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_e;

   state_e            state_q, state_d;
   logic [2:0]        op_q, param_q, rsp_op_q, rsp_op_d;
   logic [1:0]        size_q;
   logic [7:0]        source_q;
   logic [SramAw-1:0] addr_q, addr_d;
   logic [31:0]       data_q, rsp_data_q, amo_new, mask_exp, wdata_d, wmask_d;
   logic              err_q, req_err, accept, req_d, we_d;
   logic              is_get, is_put, is_arith, is_logic, is_int;

   always_comb begin
      is_get   = tl_i.a_opcode == OP_GET;
      is_put   = (tl_i.a_opcode == OP_PUT_FULL) || (tl_i.a_opcode == OP_PUT_PARTIAL);
      is_arith = tl_i.a_opcode == OP_ARITH;
      is_logic = tl_i.a_opcode == OP_LOGIC;
      is_int   = tl_i.a_opcode == OP_INTENT;
      req_err  = 1'b0;
      if (!(is_get || is_put || is_arith || is_logic || is_int)) req_err = 1'b1;
      if ((tl_i.a_address >> (SramAw + 2)) != 32'd0) req_err = 1'b1;
      if (tl_i.a_size == 2'd2 && tl_i.a_address[1:0] != 2'd0) req_err = 1'b1;
      if ((is_arith || is_logic) && (tl_i.a_size != 2'd2 || tl_i.a_mask != 4'hF)) req_err = 1'b1;
      if (is_arith && (tl_i.a_param < 3'd1 || tl_i.a_param > 3'd5)) req_err = 1'b1;
      if (is_logic && (tl_i.a_param < 3'd1 || tl_i.a_param > 3'd4)) req_err = 1'b1;
      if (is_int && (tl_i.a_param < 3'd1 || tl_i.a_param > 3'd2)) req_err = 1'b1;
      // Errored requests still answer with their type's normal opcode
      if (is_get || is_arith || is_logic) rsp_op_d = RSP_ACK_DATA;
      else if (is_int)                    rsp_op_d = RSP_HINT_ACK;
      else                                rsp_op_d = RSP_ACK;
      for (int i = 0; i < 4; i++) mask_exp[8*i +: 8] = {8{tl_i.a_mask[i]}};
   end

   always_comb begin
      amo_new = rdata_i;
      if (op_q == OP_ARITH) begin
         case (param_q)
            ARITH_MIN:  amo_new = ($signed(rdata_i) < $signed(data_q)) ? rdata_i : data_q;
            ARITH_MAX:  amo_new = ($signed(rdata_i) > $signed(data_q)) ? rdata_i : data_q;
            ARITH_MINU: amo_new = (rdata_i < data_q) ? rdata_i : data_q;
            ARITH_MAXU: amo_new = (rdata_i > data_q) ? rdata_i : data_q;
            ARITH_ADD:  amo_new = rdata_i + data_q;
            default:    amo_new = rdata_i;
         endcase
      end else begin
         case (param_q)
            LOGIC_XOR:  amo_new = rdata_i ^ data_q;
            LOGIC_OR:   amo_new = rdata_i | data_q;
            LOGIC_AND:  amo_new = rdata_i & data_q;
            LOGIC_SWAP: amo_new = data_q;
            default:    amo_new = rdata_i;
         endcase
      end
   end

   // Next state plus the next values of the registered SRAM port
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      req_d   = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      wmask_d = '0;
      case (state_q)
         IDLE: begin
            if (tl_i.a_valid) begin
               accept = 1'b1;
               if (req_err || is_int) begin
                  state_d = RESP;
               end else if (is_put) begin
                  state_d = WRITE;
                  req_d   = 1'b1;
                  we_d    = 1'b1;
                  addr_d  = tl_i.a_address[SramAw+1:2];
                  wdata_d = tl_i.a_data;
                  wmask_d = mask_exp;
               end else begin
                  state_d = READ;
                  req_d   = 1'b1;
                  addr_d  = tl_i.a_address[SramAw+1:2];
               end
            end
         end
         READ:    state_d = CAPTURE;
         CAPTURE: begin
            if (op_q == OP_GET) begin
               state_d = RESP;
            end else begin
               state_d = WRITE;
               req_d   = 1'b1;
               we_d    = 1'b1;
               addr_d  = addr_q;
               wdata_d = amo_new;
               wmask_d = '1;
            end
         end
         WRITE:   state_d = RESP;
         RESP:    if (tl_i.d_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         op_q       <= '0;
         param_q    <= '0;
         size_q     <= '0;
         source_q   <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
         rsp_op_q   <= '0;
         rsp_data_q <= '0;
         req_o      <= 1'b0;
         we_o       <= 1'b0;
         addr_o     <= '0;
         wdata_o    <= '0;
         wmask_o    <= '0;
      end else begin
         state_q <= state_d;
         req_o   <= req_d;
         we_o    <= we_d;
         addr_o  <= addr_d;
         wdata_o <= wdata_d;
         wmask_o <= wmask_d;
         if (accept) begin
            op_q       <= tl_i.a_opcode;
            param_q    <= tl_i.a_param;
            size_q     <= tl_i.a_size;
            source_q   <= tl_i.a_source;
            addr_q     <= tl_i.a_address[SramAw+1:2];
            data_q     <= tl_i.a_data;
            err_q      <= req_err;
            rsp_op_q   <= rsp_op_d;
            rsp_data_q <= '0;
         end
         if (state_q == CAPTURE) rsp_data_q <= rdata_i;
      end
   end

   always_comb begin
      tl_o         = '0;
      tl_o.a_ready = state_q == IDLE;
      if (state_q == RESP) begin
         tl_o.d_valid  = 1'b1;
         tl_o.d_opcode = rsp_op_q;
         tl_o.d_size   = size_q;
         tl_o.d_source = source_q;
         tl_o.d_data   = err_q ? 32'd0 : rsp_data_q;
         tl_o.d_error  = err_q;
      end
   end
endmodule

// File: tb/tb_tluh_sram_responder.sv
// tb/tb_tluh_sram_responder.sv - scoreboard bench for tluh_sram_responder
module tb_tluh_sram_responder;
   import tluh_pkg::*;

   typedef struct {
      logic [2:0]  op;
      logic [7:0]  src;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk, rst_n;
   tluh_h2d_t   tl_i;
   tluh_d2h_t   tl_o;
   logic        req_o, we_o;
   logic [11:0] addr_o;
   logic [31:0] wdata_o, wmask_o, rdata_i;
   logic [31:0] mem [0:4095];

   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic [31:0] last_wmask, last_wdata;
   logic [11:0] last_waddr;

   tluh_sram_responder #(.SramAw(12)) dut (
      .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_i), .tl_o(tl_o),
      .req_o(req_o), .we_o(we_o), .addr_o(addr_o),
      .wdata_o(wdata_o), .wmask_o(wmask_o), .rdata_i(rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (req_o && we_o) mem[addr_o] <= (mem[addr_o] & ~wmask_o) | (wdata_o & wmask_o);
      else if (req_o) rdata_i <= mem[addr_o];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && tl_o.d_valid && tl_i.d_ready) begin
         if (sb.size() == 0) begin
            check("sb_nonempty", 64'(sb.size()), 64'd1);
         end else begin
            mon_e = sb.pop_front();
            check("d_opcode", 64'(tl_o.d_opcode), 64'(mon_e.op));
            check("d_source", 64'(tl_o.d_source), 64'(mon_e.src));
            check("d_size", 64'(tl_o.d_size), 64'd2);
            check("d_data", 64'(tl_o.d_data), 64'(mon_e.data));
            check("d_error", 64'(tl_o.d_error), 64'(mon_e.err));
            check("d_param_sink", 64'({tl_o.d_param, tl_o.d_sink}), 64'd0);
         end
      end
   end

   task automatic do_req(input logic [2:0] op, input logic [2:0] param, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                         input logic [2:0] eop, input logic [31:0] edata, input logic eerr,
                         input int elat, input int erd, input int ewr, input int stall);
      exp_t      x;
      int        lat, rd_n, wr_n, rd_at, wr_at, waitc;
      tluh_d2h_t snap;
      x.op = eop; x.src = src; x.data = edata; x.err = eerr;
      sb.push_back(x);
      if (stall > 0) tl_i.d_ready = 1'b0;
      waitc = 0;
      @(negedge clk);
      while (!tl_o.a_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      check("a_ready_idle", 64'(tl_o.a_ready), 64'd1);
      tl_i.a_valid = 1'b1; tl_i.a_opcode = op; tl_i.a_param = param; tl_i.a_size = 2'd2;
      tl_i.a_source = src; tl_i.a_address = addr; tl_i.a_mask = mask; tl_i.a_data = data;
      @(posedge clk);
      #1 tl_i.a_valid = 1'b0;
      lat = 0; rd_n = 0; wr_n = 0; rd_at = 0; wr_at = 0;
      do begin
         @(negedge clk);
         lat++;
         if (req_o && we_o) begin
            wr_n++; wr_at = lat;
            last_wmask = wmask_o; last_wdata = wdata_o; last_waddr = addr_o;
         end
         if (req_o && !we_o) begin
            rd_n++; rd_at = lat;
         end
      end while (!tl_o.d_valid && lat < 20);
      check($sformatf("latency op%0d", op), 64'(lat), 64'(elat));
      check("read_count", 64'(rd_n), 64'(erd));
      check("write_count", 64'(wr_n), 64'(ewr));
      if (erd > 0) check("read_cycle", 64'(rd_at), 64'd1);
      if (ewr > 0) check("write_cycle", 64'(wr_at), (erd > 0) ? 64'd3 : 64'd1);
      if (stall > 0) begin
         snap = tl_o;
         for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("stall_stable", 64'(tl_o), 64'(snap));
            check("stall_a_ready", 64'(tl_o.a_ready), 64'd0);
         end
         @(posedge clk);
         #1 tl_i.d_ready = 1'b1;
         @(negedge clk);
      end
      check("a_ready_in_resp", 64'(tl_o.a_ready), 64'd0);
      @(negedge clk);
      check("a_ready_after_hs", 64'(tl_o.a_ready), 64'd1);
      check("d_valid_after_hs", 64'(tl_o.d_valid), 64'd0);
   endtask

   task automatic put(input logic [31:0] addr, input logic [31:0] data);
      do_req(OP_PUT_FULL, 3'd0, addr, 4'hF, data, 8'h7, RSP_ACK, 32'd0, 1'b0, 2, 0, 1, 0);
   endtask

   task automatic get(input logic [31:0] addr, input logic [31:0] edata);
      do_req(OP_GET, 3'd0, addr, 4'hF, 32'd0, 8'h1, RSP_ACK_DATA, edata, 1'b0, 3, 1, 0, 0);
   endtask

   task automatic amo(input logic [2:0] op, input logic [2:0] param, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] eold);
      do_req(op, param, addr, 4'hF, data, 8'h4, RSP_ACK_DATA, eold, 1'b0, 4, 1, 1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tluh_d2h_t rst_exp;
      tl_i = '0;
      tl_i.d_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_exp = '0;
      rst_exp.a_ready = 1'b1;
      check("rst_tl_o", 64'(tl_o), 64'(rst_exp));
      check("rst_sram", 64'({req_o, we_o, addr_o, wdata_o}), 64'd0);
      check("rst_wmask", 64'(wmask_o), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      do_req(OP_PUT_FULL, 3'd0, 32'h10, 4'hF, 32'hDEADBEEF, 8'h3, RSP_ACK, 32'd0, 1'b0, 2, 0, 1, 0);
      check("put_addr", 64'(last_waddr), 64'd4);
      check("put_wmask", 64'(last_wmask), 64'hFFFF_FFFF);
      get(32'h10, 32'hDEADBEEF);
      do_req(OP_PUT_PARTIAL, 3'd0, 32'h10, 4'b0010, 32'h0000AB00, 8'h2, RSP_ACK, 32'd0, 1'b0, 2, 0, 1, 0);
      check("partial_wmask", 64'(last_wmask), 64'h0000_FF00);
      get(32'h10, 32'hDEADABEF);

      put(32'h20, 32'hFFFFFFFF);
      amo(OP_ARITH, ARITH_MIN, 32'h20, 32'd5, 32'hFFFFFFFF);
      check("min_wdata", 64'(last_wdata), 64'hFFFF_FFFF);
      check("amo_wmask", 64'(last_wmask), 64'hFFFF_FFFF);
      get(32'h20, 32'hFFFFFFFF);
      amo(OP_ARITH, ARITH_MINU, 32'h20, 32'd5, 32'hFFFFFFFF);
      get(32'h20, 32'd5);
      amo(OP_ARITH, ARITH_ADD, 32'h20, 32'hFFFFFFFC, 32'd5);
      get(32'h20, 32'd1);
      amo(OP_ARITH, ARITH_MAX, 32'h20, 32'h80000000, 32'd1);
      get(32'h20, 32'd1);
      amo(OP_ARITH, ARITH_MAXU, 32'h20, 32'h80000000, 32'd1);
      get(32'h20, 32'h80000000);

      put(32'h30, 32'h0F0F0F0F);
      amo(OP_LOGIC, LOGIC_SWAP, 32'h30, 32'h12345678, 32'h0F0F0F0F);
      get(32'h30, 32'h12345678);
      amo(OP_LOGIC, LOGIC_AND, 32'h30, 32'hFFFF0000, 32'h12345678);
      get(32'h30, 32'h12340000);
      amo(OP_LOGIC, LOGIC_XOR, 32'h20, 32'h80000001, 32'h80000000);
      get(32'h20, 32'd1);

      do_req(OP_GET, 3'd0, 32'h4000, 4'hF, 32'd0, 8'h9, RSP_ACK_DATA, 32'd0, 1'b1, 1, 0, 0, 0);
      do_req(OP_ARITH, 3'd6, 32'h20, 4'hF, 32'd1, 8'hA, RSP_ACK_DATA, 32'd0, 1'b1, 1, 0, 0, 0);
      do_req(OP_INTENT, 3'd1, 32'h20, 4'hF, 32'd0, 8'hB, RSP_HINT_ACK, 32'd0, 1'b0, 1, 0, 0, 0);
      do_req(OP_PUT_FULL, 3'd0, 32'h11, 4'hF, 32'h1, 8'hC, RSP_ACK, 32'd0, 1'b1, 1, 0, 0, 0);
      do_req(3'd6, 3'd0, 32'h20, 4'hF, 32'd0, 8'hD, RSP_ACK, 32'd0, 1'b1, 1, 0, 0, 0);
      do_req(OP_LOGIC, LOGIC_OR, 32'h20, 4'h7, 32'hFF, 8'hE, RSP_ACK_DATA, 32'd0, 1'b1, 1, 0, 0, 0);
      get(32'h20, 32'd1);

      do_req(OP_GET, 3'd0, 32'h30, 4'hF, 32'd0, 8'h5, RSP_ACK_DATA, 32'h12340000, 1'b0, 3, 1, 0, 5);

      // Abort an atomic in its capture cycle: nothing may be written or answered
      @(negedge clk);
      tl_i.a_valid = 1'b1; tl_i.a_opcode = OP_ARITH; tl_i.a_param = ARITH_ADD; tl_i.a_size = 2'd2;
      tl_i.a_address = 32'h30; tl_i.a_mask = 4'hF; tl_i.a_data = 32'h11111111;
      @(posedge clk);
      #1 tl_i.a_valid = 1'b0;
      @(negedge clk);
      check("abort_read_strobe", 64'({req_o, we_o}), 64'b10);
      @(negedge clk);
      rst_n = 1'b0;
      #1 check("abort_rst_outputs", 64'({req_o, we_o, tl_o.d_valid}), 64'd0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("abort_quiet", 64'({req_o, we_o, tl_o.d_valid}), 64'd0);
      end
      get(32'h30, 32'h12340000);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
